// File: rtl/nextio_pkg.sv
// Shared register-file addresses, UART CSR bit positions and the TX sequencer state type.
// Latency: n/a (declarations and pure combinational helpers only).
// Backpressure: n/a.
package nextio_pkg;

  // Register-file word addresses
  localparam logic [15:0] RF_GPIO_ADDR = 16'h0000;
  localparam logic [15:0] RF_DATA_ADDR = 16'h0001;
  localparam logic [15:0] RF_CSR_ADDR  = 16'h0002;

  // UART CSR bit positions
  localparam int CSR_START = 0;
  localparam int CSR_BUSY  = 1;
  localparam int CSR_DONE  = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP,
    DONE_WB
  } tx_state_t;

  // Frame accepted: clear START, set BUSY, keep DONE and the upper bits
  function automatic logic [31:0] csr_load_val(input logic [31:0] csr);
    return {csr[31:3], csr[CSR_DONE], 1'b1, 1'b0};
  endfunction

  // Frame finished: set DONE, clear BUSY, keep START so a pending request runs next
  function automatic logic [31:0] csr_done_val(input logic [31:0] csr);
    return {csr[31:3], 1'b1, 1'b0, csr[CSR_START]};
  endfunction

endpackage

// File: rtl/nextio_uart_tx_ctrl_baud.sv
// Baud divider: free-running 0..CLK_DIV-1 counter with a one-cycle tick on the last count.
// Latency: tick is combinational from the count register.
// Backpressure: none; clear holds the count at zero.
module uart_baud_tick #(
  parameter int CLK_DIV = 234
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  // Count one bit period, reload on each bit boundary, hold at zero while cleared
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/nextio_uart_tx_ctrl.sv
// UART TX sequencer: START in CSR -> latch data byte, send 8N1 LSB first, write BUSY/DONE back.
// Latency: START seen -> tx low after 2 cycles; frame 10*CLK_DIV (11*CLK_DIV with NEXTIO_UART_PARITY_EN).
// Backpressure: controller owns the RF write port in LOAD/DONE_WB; a colliding CPU write is stalled 1 cycle.
module nextio_uart_tx_ctrl
  import nextio_pkg::*;
#(
  parameter int          CLK_DIV   = 234,
  parameter logic [15:0] DATA_ADDR = RF_DATA_ADDR,
  parameter logic [15:0] CSR_ADDR  = RF_CSR_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] uart_io_reg,
  input  logic [31:0] uart_csr_reg,
  input  logic        cpu_wen,
  input  logic [15:0] cpu_waddr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_wstall,
  output logic        io_wen,
  output logic [15:0] io_waddr,
  output logic [31:0] io_wdata,
  output logic        tx,
  output logic        busy
);

  // The data register is only read through uart_io_reg; its address must not alias the CSR
  if (CLK_DIV < 2 || DATA_ADDR == CSR_ADDR) begin : g_bad_cfg
    $error("nextio_uart_tx_ctrl: CLK_DIV must be >= 2 and DATA_ADDR must differ from CSR_ADDR");
  end

  tx_state_t   state;
  logic [7:0]  shift;
  logic [2:0]  bit_idx;
  logic        tick;
  logic        baud_clear;
  logic        ctrl_wr;
  logic [31:0] ctrl_wdata;
  logic        unused_io_hi;

  assign unused_io_hi = ^uart_io_reg[31:8];

`ifdef NEXTIO_UART_PARITY_EN
  logic par;
`endif

  // Baud count restarts at the first START cycle because it is held clear outside the frame
  assign baud_clear = (state == IDLE) || (state == LOAD) || (state == DONE_WB);

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clear),
    .tick  (tick)
  );

  assign ctrl_wr    = (state == LOAD) || (state == DONE_WB);
  assign ctrl_wdata = (state == LOAD) ? csr_load_val(uart_csr_reg) : csr_done_val(uart_csr_reg);

  // Write-port mux: controller wins, CPU is told to hold its request for that cycle
  always_comb begin
    io_wen     = cpu_wen;
    io_waddr   = cpu_waddr;
    io_wdata   = cpu_wdata;
    cpu_wstall = 1'b0;
    if (ctrl_wr) begin
      io_wen     = 1'b1;
      io_waddr   = CSR_ADDR;
      io_wdata   = ctrl_wdata;
      cpu_wstall = cpu_wen;
    end
  end

  // Frame sequencer; tx and busy are registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      shift   <= '0;
      bit_idx <= '0;
`ifdef NEXTIO_UART_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (uart_csr_reg[CSR_START]) begin
            state   <= LOAD;
            busy    <= 1'b1;
            shift   <= uart_io_reg[7:0];
            bit_idx <= '0;
`ifdef NEXTIO_UART_PARITY_EN
            par     <= ^uart_io_reg[7:0];
`endif
          end
        end
        LOAD: begin
          state <= START;
          tx    <= 1'b0;
        end
        START: begin
          if (tick) begin
            state <= DATA;
            tx    <= shift[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
`ifdef NEXTIO_UART_PARITY_EN
              state <= PARITY;
              tx    <= par;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end
        end
`ifdef NEXTIO_UART_PARITY_EN
        PARITY: begin
          if (tick) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            state <= DONE_WB;
          end
        end
        DONE_WB: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nextio_uart_tx_ctrl.sv
// Directed bench for nextio_uart_tx_ctrl with a small register-file model on the muxed write port.
// Frames run at CLK_DIV=4; all checks sample on the falling edge.
// CPU writes retry while cpu_wstall is high.
module tb_nextio_uart_tx_ctrl;

  localparam int CLK_DIV = 4;
  localparam logic [15:0] GPIO_A = 16'h0000;
  localparam logic [15:0] DATA_A = 16'h0001;
  localparam logic [15:0] CSR_A  = 16'h0002;
`ifdef NEXTIO_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_clr = 1'b1;
  logic [31:0] uart_io_reg, uart_csr_reg;
  logic        cpu_wen = 1'b0;
  logic [15:0] cpu_waddr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_wstall, io_wen, tx, busy;
  logic [15:0] io_waddr;
  logic [31:0] io_wdata;
  logic [31:0] regs [0:3];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nextio_uart_tx_ctrl #(.CLK_DIV(CLK_DIV), .DATA_ADDR(DATA_A), .CSR_ADDR(CSR_A)) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_io_reg  (uart_io_reg),
    .uart_csr_reg (uart_csr_reg),
    .cpu_wen      (cpu_wen),
    .cpu_waddr    (cpu_waddr),
    .cpu_wdata    (cpu_wdata),
    .cpu_wstall   (cpu_wstall),
    .io_wen       (io_wen),
    .io_waddr     (io_waddr),
    .io_wdata     (io_wdata),
    .tx           (tx),
    .busy         (busy)
  );

  // Register file: single write port, not touched by the DUT reset
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (io_wen && io_waddr < 16'd4) begin
      regs[io_waddr[1:0]] <= io_wdata;
    end
  end

  assign uart_io_reg  = regs[1];
  assign uart_csr_reg = regs[2];

  // CPU store: hold the request while stalled, return on the edge after it is accepted
  task automatic cpu_write(input logic [15:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    cpu_wen = 1'b1; cpu_waddr = a; cpu_wdata = d;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (!cpu_wstall) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL cpu_write_accept: addr %h still stalled, required accepted within 4 cycles", a);
    end
    @(negedge clk);
    cpu_wen = 1'b0;
  endtask

  // Walks one frame starting in the IDLE cycle that first sees START; ends in the IDLE cycle after DONE_WB
  task automatic run_frame(input logic [7:0] d, input logic [31:0] csr_in, input bit gpio_in_load,
                           input bit mid_wr, input logic [15:0] mid_addr, input logic [31:0] mid_val,
                           output int busy_cnt, output int act_cnt);
    logic [NB-1:0] bits;
    logic [31:0]   load_val, cur, done_val;
    logic          exp_tx;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
`ifdef NEXTIO_UART_PARITY_EN
    bits[9] = ^d;
`endif
    bits[NB-1] = 1'b1;
    load_val = {csr_in[31:3], csr_in[2], 2'b10};
    cur = load_val;
    busy_cnt = 0;
    act_cnt = -1;

    vectors++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_before_load: busy=%b tx=%b, required busy=0 tx=1", busy, tx);
    end

    @(negedge clk);
    if (busy) busy_cnt++;
    vectors++;
    if (io_wen !== 1'b1 || io_waddr !== CSR_A || io_wdata !== load_val) begin
      miscompares++;
      $display("FAIL load_csr_write: wen=%b addr=%h data=%h, required 1 %h %h", io_wen, io_waddr, io_wdata, CSR_A, load_val);
    end
    if (gpio_in_load) begin
      cpu_wen = 1'b1; cpu_waddr = GPIO_A; cpu_wdata = 32'h55;
      #1;
      vectors++;
      if (cpu_wstall !== 1'b1 || io_waddr !== CSR_A || io_wdata !== load_val) begin
        miscompares++;
        $display("FAIL load_stall: stall=%b addr=%h data=%h, required 1 %h %h", cpu_wstall, io_waddr, io_wdata, CSR_A, load_val);
      end
    end

    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (io_wen && !cpu_wen && io_waddr == CSR_A) begin
        act_cnt = k;
        break;
      end
      exp_tx = (k < NB*CLK_DIV) ? bits[k/CLK_DIV] : 1'b1;
      vectors++;
      if (tx !== exp_tx || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL frame_tx cycle %0d: tx=%b busy=%b, required tx=%b busy=1", k, tx, busy, exp_tx);
      end
      if (k == 0) begin
        vectors++;
        if (uart_csr_reg !== load_val || cpu_wstall !== 1'b0) begin
          miscompares++;
          $display("FAIL csr_in_frame: csr=%h stall=%b, required %h 0", uart_csr_reg, cpu_wstall, load_val);
        end
      end
      if (gpio_in_load && k == 1) begin
        vectors++;
        if (regs[0] !== 32'h55) begin
          miscompares++;
          $display("FAIL gpio_after_stall: gpio=%h, required 00000055", regs[0]);
        end
        cpu_wen = 1'b0;
      end
      if (mid_wr && k == 20) begin
        cpu_wen = 1'b1; cpu_waddr = mid_addr; cpu_wdata = mid_val;
        #1;
        vectors++;
        if (cpu_wstall !== 1'b0) begin
          miscompares++;
          $display("FAIL mid_frame_stall: stall=%b, required 0", cpu_wstall);
        end
      end
      if (mid_wr && k == 21) begin
        cpu_wen = 1'b0;
        if (mid_addr == CSR_A) cur = mid_val;
      end
    end

    done_val = {cur[31:3], 1'b1, 1'b0, cur[0]};
    vectors++;
    if (io_wdata !== done_val || busy !== 1'b1 || tx !== 1'b1) begin
      miscompares++;
      $display("FAIL done_wb_write: data=%h busy=%b tx=%b, required %h 1 1", io_wdata, busy, tx, done_val);
    end
    vectors++;
    if (act_cnt !== NB*CLK_DIV) begin
      miscompares++;
      $display("FAIL frame_length: %0d cycles, required %0d", act_cnt, NB*CLK_DIV);
    end

    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || uart_csr_reg !== done_val || io_wen !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_done: busy=%b csr=%h wen=%b, required 0 %h 0", busy, uart_csr_reg, io_wen, done_val);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_clr = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0 || io_wen !== 1'b0 || cpu_wstall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: tx=%b busy=%b wen=%b stall=%b, required 1 0 0 0", tx, busy, io_wen, cpu_wstall);
    end
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    cpu_wen = 1'b1; cpu_waddr = GPIO_A; cpu_wdata = 32'h12;
    #1;
    vectors++;
    if (io_wen !== 1'b1 || io_waddr !== GPIO_A || io_wdata !== 32'h12 || cpu_wstall !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_passthrough: wen=%b addr=%h data=%h stall=%b busy=%b, required 1 0000 00000012 0 0",
               io_wen, io_waddr, io_wdata, cpu_wstall, busy);
    end
    @(negedge clk);
    cpu_wen = 1'b0;
  endtask

  task automatic test_frame();
    int bc, ac;
    cpu_write(DATA_A, 32'hA5);
    cpu_write(CSR_A, 32'h1);
    run_frame(8'hA5, 32'h1, 1'b0, 1'b0, 16'h0, 32'h0, bc, ac);
    vectors++;
    if (bc !== 2 + NB*CLK_DIV) begin
      miscompares++;
      $display("FAIL busy_length: %0d cycles, required %0d", bc, 2 + NB*CLK_DIV);
    end
    vectors++;
    if (uart_csr_reg !== 32'h4) begin
      miscompares++;
      $display("FAIL frame_csr_end: csr=%h, required 00000004", uart_csr_reg);
    end
  endtask

  task automatic test_cpu_stall();
    int bc, ac;
    cpu_write(DATA_A, 32'h3C);
    cpu_write(GPIO_A, 32'h0);
    cpu_write(CSR_A, 32'h1);
    run_frame(8'h3C, 32'h1, 1'b1, 1'b0, 16'h0, 32'h0, bc, ac);
    vectors++;
    if (regs[0] !== 32'h55 || uart_csr_reg !== 32'h4) begin
      miscompares++;
      $display("FAIL stall_end_state: gpio=%h csr=%h, required 00000055 00000004", regs[0], uart_csr_reg);
    end
  endtask

  task automatic test_back_to_back();
    int bc, ac;
    cpu_write(DATA_A, 32'h5A);
    cpu_write(CSR_A, 32'h1);
    run_frame(8'h5A, 32'h1, 1'b0, 1'b1, CSR_A, 32'h1, bc, ac);
    vectors++;
    if (uart_csr_reg !== 32'h5) begin
      miscompares++;
      $display("FAIL b2b_csr_between: csr=%h, required 00000005", uart_csr_reg);
    end
    run_frame(8'h5A, 32'h5, 1'b0, 1'b0, 16'h0, 32'h0, bc, ac);
    vectors++;
    if (uart_csr_reg !== 32'h4) begin
      miscompares++;
      $display("FAIL b2b_csr_end: csr=%h, required 00000004", uart_csr_reg);
    end
  endtask

  task automatic test_upper_bits();
    int bc, ac;
    cpu_write(DATA_A, 32'h81);
    cpu_write(CSR_A, 32'hF000_0001);
    // Data register rewritten mid-frame must not disturb the byte on the wire
    run_frame(8'h81, 32'hF000_0001, 1'b0, 1'b1, DATA_A, 32'hFF, bc, ac);
    vectors++;
    if (uart_csr_reg !== 32'hF000_0004) begin
      miscompares++;
      $display("FAIL upper_bits_end: csr=%h, required f0000004", uart_csr_reg);
    end
  endtask

  task automatic test_reset_mid_frame();
    int bc, ac;
    cpu_write(DATA_A, 32'hC3);
    cpu_write(CSR_A, 32'h1);
    repeat (19) @(negedge clk);
    vectors++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL in_data_bit3: tx=%b busy=%b, required 0 1", tx, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0 || io_wen !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: tx=%b busy=%b wen=%b, required 1 0 0", tx, busy, io_wen);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (uart_csr_reg !== 32'h2 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL csr_after_reset: csr=%h busy=%b, required 00000002 0", uart_csr_reg, busy);
    end
    cpu_write(DATA_A, 32'h96);
    cpu_write(CSR_A, 32'h3);
    run_frame(8'h96, 32'h3, 1'b0, 1'b0, 16'h0, 32'h0, bc, ac);
    vectors++;
    if (uart_csr_reg !== 32'h4) begin
      miscompares++;
      $display("FAIL restart_csr_end: csr=%h, required 00000004", uart_csr_reg);
    end
  endtask

  task automatic test_parity();
    int bc, ac, want;
`ifdef NEXTIO_UART_PARITY_EN
    want = 44;
`else
    want = 40;
`endif
    cpu_write(DATA_A, 32'h07);
    cpu_write(CSR_A, 32'h1);
    run_frame(8'h07, 32'h1, 1'b0, 1'b0, 16'h0, 32'h0, bc, ac);
    vectors++;
    if (ac !== want) begin
      miscompares++;
      $display("FAIL parity_frame_len: %0d cycles, required %0d", ac, want);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_frame();
    test_cpu_stall();
    test_back_to_back();
    test_upper_bits();
    test_reset_mid_frame();
    test_parity();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nextio_uart_tx_ctrl.md
Name: nextio_uart_tx_ctrl

Overview:
Hardware sequencer for the UART registers of the NextIO register file.
- Watches the UART CSR for a software START request and latches the data byte from the UART data register.
- Serialises the byte on `tx` (8N1, LSB first) and writes status back into the CSR.
- Shares the register file's single write port with the CPU store path: controller has priority, CPU is stalled.

Parameters:
- CLK_DIV, 234: clock cycles per UART bit; legal range ≥2.
- DATA_ADDR, 16'h0001: register-file word address of the UART data register.
- CSR_ADDR, 16'h0002: register-file word address of the UART CSR.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- uart_io_reg  in  32  current data register contents; byte in [7:0]
- uart_csr_reg  in  32  current CSR contents
- cpu_wen  in  1  CPU write request to the register file
- cpu_waddr  in  16  CPU write address
- cpu_wdata  in  32  CPU write data
- cpu_wstall  out  1  CPU write not accepted this cycle; CPU holds its request
- io_wen  out  1  muxed write enable to the register file
- io_waddr  out  16  muxed write address
- io_wdata  out  32  muxed write data
- tx  out  1  UART serial output, idle high
- busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Interface: one clock `clk`; `rst` is synchronous, active-high.
- CSR bits:
  - [0] START: software sets.
  - [1] BUSY: hardware sets and clears.
  - [2] DONE: hardware sets, software clears.
  - [31:3]: preserved by every hardware write.
- Reset values: state=IDLE, tx=1, busy=0, io_wen=0, cpu_wstall=0, baud counter=0, bit index=0.
  - Register-file contents are not reset.
- FSM transitions:
  - IDLE -> LOAD when uart_csr_reg[0]=1. Latch uart_io_reg[7:0] into the shift register.
  - LOAD, 1 cycle: controller writes CSR_ADDR with {csr[31:3], csr[2], 1'b1, 1'b0}, i.e. START cleared, BUSY set. -> START.
  - START: tx=0 for CLK_DIV cycles. -> DATA.
  - DATA: tx=shift[0] for CLK_DIV cycles per bit; shift right; 8 bits. -> STOP after bit 7.
  - STOP: tx=1 for CLK_DIV cycles. -> DONE_WB.
  - DONE_WB, 1 cycle: controller writes CSR_ADDR with {csr[31:3], 1'b1, 1'b0, csr[0]}, i.e. DONE set, BUSY cleared, START preserved. -> IDLE.
- Baud counter:
  - Counts 0..CLK_DIV-1 and reloads to 0 on each bit boundary.
  - Cleared on entry to START.
- Latency and frame length:
  - First cycle with START visible -> first tx low = 2 cycles (IDLE, LOAD).
  - Frame = 10*CLK_DIV cycles of tx activity.
  - DONE visible in uart_csr_reg one cycle after DONE_WB.
- Write-port arbitration (combinational):
  - In LOAD/DONE_WB the controller drives io_*. If cpu_wen=1, assert cpu_wstall=1; the CPU write is dropped that cycle and retried next cycle.
  - Otherwise io_* = cpu_* and cpu_wstall=0.
  - Controller write lasts exactly 1 cycle, so maximum stall is 1 cycle.
- CSR read-modify-write uses the uart_csr_reg value in the same cycle.
  - A CPU CSR write in the prior cycle is already visible and is not lost.
  - A CPU write colliding in the same cycle is stalled, so it cannot be lost either.
- START set again while busy: ignored until IDLE.
  - DONE_WB preserves START, so IDLE immediately begins a new frame. Back-to-back gap = 2 cycles.
- CPU writes to DATA_ADDR mid-frame: no effect on the current frame, because the byte is already latched.
- rst mid-frame:
  - FSM returns to IDLE next edge; tx=1.
  - The CSR may retain BUSY=1. The trigger does not depend on BUSY, so there is no lockup.

Optional Feature:
- Macro: NEXTIO_UART_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits) for CLK_DIV cycles.
  - Frame = 11*CLK_DIV.
- Undefined:
  - No PARITY state; 8N1 framing, frame = 10*CLK_DIV.

Decomposition:
- Package nextio_pkg:
  - Address localparams for GPIO, DATA, and CSR (0, 1, 2).
  - CSR bit indices: START=0, BUSY=1, DONE=2.
  - State enum typedef tx_state_t {IDLE, LOAD, START, DATA, PARITY, STOP, DONE_WB}.
- Sub-module uart_baud_tick:
  - Parameter CLK_DIV; inputs clk, rst, clear.
  - Output tick: 1-cycle pulse when count=CLK_DIV-1.

Test Plan:
1. CLK_DIV=4; data=0xA5, CSR=0x1.
   - io write {CSR_ADDR, 0x2} in cycle 2.
   - tx sequence 0,1,0,1,0,0,1,0,1,1, each for 4 cycles.
   - CSR=0x4 after DONE_WB; busy high 42 cycles.
2. cpu_wen=1 to GPIO addr 0 with data 0x55 during the LOAD cycle.
   - cpu_wstall=1 for exactly 1 cycle.
   - GPIO reg=0x55 one cycle later.
   - CSR=0x2.
3. CPU sets CSR=0x1 mid-frame.
   - Next frame starts 2 cycles after DONE_WB.
   - CSR passes through 0x5 (START held, DONE set) and then 0x6 (LOAD of the second frame: START cleared, BUSY set).
4. CSR=0xF0000001.
   - Upper bits preserved: 0xF0000002 during the frame, 0xF0000004 at end.
5. rst asserted in DATA bit 3.
   - Next cycle tx=1, busy=0, io_wen=0.
   - Setting START again yields a full, correct frame.
6. With NEXTIO_UART_PARITY_EN, data=0x07.
   - Parity bit=1 after bit 7.
   - Frame 44 cycles at CLK_DIV=4.
